// File: rtl/fix_tx_arbiter.sv
// fix_tx_arbiter: shares the TOE transmit FIFO between the FIX initiator and
// acceptor engines, one whole message at a time, round-robin.
// Optional stall watchdog: define FIX_ARB_TIMEOUT_EN.
module fix_tx_arbiter #(
  parameter int MAX_MSG_LEN    = 500,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_write_i_i,
  input  logic [7:0] message_i_i,
  input  logic       end_i_i,
  input  logic [1:0] id_i_i,
  output logic       ready_i_o,
  input  logic       fifo_write_a_i,
  input  logic [7:0] message_a_i,
  input  logic       end_a_i,
  input  logic [1:0] id_a_i,
  output logic       ready_a_o,
  input  logic       tx_full_i,
  output logic       tx_write_o,
  output logic [7:0] tx_data_o,
  output logic       tx_end_o,
  output logic [1:0] tx_id_o,
  output logic       len_err_o,
  output logic       tx_abort_o
);
  localparam int CW = $clog2(MAX_MSG_LEN + 1);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_A, DRAIN_I, DRAIN_A} state_t;

  state_t        state;
  logic          last_a;   // round-robin memory: 1 = acceptor owned the last message
  logic [CW-1:0] byte_cnt;

  logic       sel_a, granted, accept, at_max, timeout;
  logic       cur_write, cur_end;
  logic [7:0] cur_data;

  // Steer the owning requester's stream into one datapath
  assign sel_a     = (state == GRANT_A) || (state == DRAIN_A);
  assign granted   = (state == GRANT_I) || (state == GRANT_A);
  assign cur_write = sel_a ? fifo_write_a_i : fifo_write_i_i;
  assign cur_data  = sel_a ? message_a_i    : message_i_i;
  assign cur_end   = sel_a ? end_a_i        : end_i_i;

  // Granted side follows FIFO backpressure; draining side is always drained
  assign ready_i_o = ((state == GRANT_I) && !tx_full_i) || (state == DRAIN_I);
  assign ready_a_o = ((state == GRANT_A) && !tx_full_i) || (state == DRAIN_A);
  assign accept    = cur_write && (sel_a ? ready_a_o : ready_i_o);
  assign at_max    = (byte_cnt == CW'(MAX_MSG_LEN - 1));

`ifdef FIX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          idle_tick;

  // Full-FIFO cycles neither count nor clear: only requester silence is a stall
  assign idle_tick = granted && !tx_full_i && !cur_write;
  assign timeout   = idle_tick && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Consecutive-stall counter, restarted by every accepted byte or a new grant
  always_ff @(posedge clk) begin
    if (rst || !granted || accept) idle_cnt <= '0;
    else if (idle_tick)            idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Arbitration FSM with registered TOE-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_a     <= 1'b1;
      byte_cnt   <= '0;
      tx_write_o <= 1'b0;
      tx_data_o  <= 8'h00;
      tx_end_o   <= 1'b0;
      tx_id_o    <= 2'b00;
      len_err_o  <= 1'b0;
      tx_abort_o <= 1'b0;
    end else begin
      tx_write_o <= 1'b0;
      tx_end_o   <= 1'b0;
      len_err_o  <= 1'b0;
      tx_abort_o <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_write_i_i && (!fifo_write_a_i || last_a)) begin
            state    <= GRANT_I;
            tx_id_o  <= id_i_i;
            byte_cnt <= '0;
          end else if (fifo_write_a_i) begin
            state    <= GRANT_A;
            tx_id_o  <= id_a_i;
            byte_cnt <= '0;
          end
        end
        GRANT_I, GRANT_A: begin
          if (accept) begin
            tx_write_o <= 1'b1;
            tx_data_o  <= cur_data;
            byte_cnt   <= byte_cnt + CW'(1);
            if (cur_end) begin
              tx_end_o <= 1'b1;
              last_a   <= sel_a;
              state    <= IDLE;
            end else if (at_max) begin
              // Truncate: close the message downstream, swallow the rest upstream
              tx_end_o  <= 1'b1;
              len_err_o <= 1'b1;
              last_a    <= sel_a;
              state     <= sel_a ? DRAIN_A : DRAIN_I;
            end
          end else if (timeout) begin
            tx_abort_o <= 1'b1;
            last_a     <= sel_a;
            state      <= sel_a ? DRAIN_A : DRAIN_I;
          end
        end
        DRAIN_I, DRAIN_A: begin
          if (accept && cur_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
